montgomery_req_arbiter: RTL and testbench

Round-robin arbiter sharing one pipelined Montgomery reducer (`montgomery_pipelined`) between two requesters, e.g. the NTT butterfly path and the pointwise-multiply path. It accepts operands over valid/ready handshakes and issues at most one operand per cycle to the reducer. It tags every issued operand, routes each reducer result back to the requester that issued it, and holds results in per-requester response FIFOs. Per-requester credit counters guarantee that the FIFOs never overflow, even though the reducer has no backpressure.

---
 rtl/montgomery_req_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_montgomery_req_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_req_arbiter.sv
// Round-robin arbiter sharing one pipelined Montgomery reducer between two requesters.
// Define MONT_ARB_CHECK_EN to build the sticky tag/valid and FIFO-overflow checker on error_o.
package params_pkg;
   localparam logic [63:0] MODULUS        = 64'd8380417;
   localparam logic [63:0] MODULUS_LENGTH = 64'd23;
   localparam logic [63:0] MOD_INV        = 64'd58728449;
endpackage

module montgomery_req_arbiter
   import params_pkg::*;
#(
   parameter int DATA_LENGTH = 64,
   parameter int LATENCY     = 4,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [1:0]                  req_valid_i,
   input  logic [1:0][DATA_LENGTH-1:0] req_data_i,
   output logic [1:0]                  req_ready_o,
   output logic                        red_start_o,
   output logic [DATA_LENGTH-1:0]      red_x_o,
   output logic [DATA_LENGTH-1:0]      red_q_o,
   output logic [DATA_LENGTH-1:0]      red_q_bl_o,
   output logic [DATA_LENGTH-1:0]      red_qinv_o,
   input  logic [DATA_LENGTH-1:0]      red_result_i,
   input  logic                        red_valid_i,
   output logic [1:0]                  rsp_valid_o,
   output logic [1:0][DATA_LENGTH-1:0] rsp_data_o,
   input  logic [1:0]                  rsp_ready_i,
   output logic                        idle_o,
   output logic                        error_o
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [1:0]             elig, grant, pop, push, full;
   logic                   last_q, last_d;
   logic                   start_q, start_d;
   logic                   id_q, id_d;
   logic [DATA_LENGTH-1:0] x_q, x_d;
   logic [LATENCY-1:0]     tag_vld_q, tag_vld_d;
   logic [LATENCY-1:0]     tag_id_q, tag_id_d;
   logic                   tag_out_vld, tag_out_id;
   logic [1:0][CW-1:0]     cnt_q, cnt_d;
   logic [1:0][CW-1:0]     occ_q, occ_d;
   logic [1:0][PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [DATA_LENGTH-1:0] mem_q [2][FIFO_DEPTH];
   logic                   idle_q, idle_d;

   assign red_q_o    = DATA_LENGTH'(MODULUS);
   assign red_q_bl_o = DATA_LENGTH'(MODULUS_LENGTH);
   assign red_qinv_o = DATA_LENGTH'(MOD_INV);

   // Grant goes to the eligible requester; on a tie, to the one that was not served last.
   always_comb begin
      elig  = '0;
      grant = '0;
      for (int k = 0; k < 2; k++) begin
         elig[k] = req_valid_i[k] && (cnt_q[k] < DEPTH_C);
      end
      if (elig == 2'b11) begin
         grant = last_q ? 2'b01 : 2'b10;
      end else begin
         grant = elig;
      end
      if (rst_i) begin
         grant = '0;
      end
   end

   assign req_ready_o = grant;

   always_comb begin
      last_d  = last_q;
      start_d = |grant;
      id_d    = id_q;
      x_d     = x_q;
      if (|grant) begin
         id_d   = grant[1];
         last_d = grant[1];
         x_d    = req_data_i[grant[1]];
      end
   end

   // Tag pipeline is fed from the registered issue so its output lines up with red_valid_i.
   always_comb begin
      tag_vld_d    = '0;
      tag_id_d     = '0;
      tag_vld_d[0] = start_q;
      tag_id_d[0]  = id_q;
      for (int i = 1; i < LATENCY; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end
   end

   assign tag_out_vld = tag_vld_q[LATENCY-1];
   assign tag_out_id  = tag_id_q[LATENCY-1];

   always_comb begin
      full   = '0;
      pop    = '0;
      push   = '0;
      occ_d  = occ_q;
      cnt_d  = cnt_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      for (int k = 0; k < 2; k++) begin
         full[k]   = (occ_q[k] == DEPTH_C);
         pop[k]    = rsp_ready_i[k] && (occ_q[k] != '0);
         push[k]   = tag_out_vld && (tag_out_id == 1'(k)) && (!full[k] || pop[k]);
         occ_d[k]  = occ_q[k] + CW'(push[k]) - CW'(pop[k]);
         cnt_d[k]  = cnt_q[k] + CW'(grant[k]) - CW'(pop[k]);
         wptr_d[k] = wptr_q[k] + PW'(push[k]);
         rptr_d[k] = rptr_q[k] + PW'(pop[k]);
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         rsp_valid_o[k] = (occ_q[k] != '0);
         rsp_data_o[k]  = rsp_valid_o[k] ? mem_q[k][rptr_q[k]] : '0;
      end
   end

   assign idle_d      = (tag_vld_d == '0) && !start_d && (occ_d == '0) && (cnt_d == '0);
   assign idle_o      = idle_q;
   assign red_start_o = start_q;
   assign red_x_o     = x_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q    <= 1'b1;
         start_q   <= 1'b0;
         x_q       <= '0;
         tag_vld_q <= '0;
         cnt_q     <= '0;
         occ_q     <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         idle_q    <= 1'b1;
      end else begin
         last_q    <= last_d;
         start_q   <= start_d;
         x_q       <= x_d;
         tag_vld_q <= tag_vld_d;
         cnt_q     <= cnt_d;
         occ_q     <= occ_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         idle_q    <= idle_d;
      end
   end

   always_ff @(posedge clk_i) begin
      id_q     <= id_d;
      tag_id_q <= tag_id_d;
      for (int k = 0; k < 2; k++) begin
         if (push[k]) begin
            mem_q[k][wptr_q[k]] <= red_result_i;
         end
      end
   end

`ifdef MONT_ARB_CHECK_EN
   logic error_q, error_d;

   always_comb begin
      error_d = error_q;
      if (red_valid_i != tag_out_vld) begin
         error_d = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
         if (tag_out_vld && (tag_out_id == 1'(k)) && full[k] && !pop[k]) begin
            error_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   assign error_o = error_q;
`else
   logic unused_red_valid;
   assign unused_red_valid = red_valid_i;
   assign error_o          = 1'b0;
`endif

endmodule

// File: tb/tb_montgomery_req_arbiter.sv
// Bench for montgomery_req_arbiter: queue-based reference model, behavioural reducer,
// directed scenarios followed by randomized traffic.
module tb_montgomery_req_arbiter;
   localparam int DL    = 64;
   localparam int LAT   = 4;
   localparam int DEPTH = 4;
   localparam logic [63:0] Q = 64'd8380417;
`ifdef MONT_ARB_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_i;
   logic [1:0]          req_valid_i;
   logic [1:0][DL-1:0]  req_data_i;
   logic [1:0]          req_ready_o;
   logic                red_start_o;
   logic [DL-1:0]       red_x_o, red_q_o, red_q_bl_o, red_qinv_o;
   logic [DL-1:0]       red_result_i;
   logic                red_valid_i;
   logic [1:0]          rsp_valid_o;
   logic [1:0][DL-1:0]  rsp_data_o;
   logic [1:0]          rsp_ready_i;
   logic                idle_o, error_o;

   montgomery_req_arbiter #(.DATA_LENGTH(DL), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
      .req_ready_o(req_ready_o), .red_start_o(red_start_o), .red_x_o(red_x_o),
      .red_q_o(red_q_o), .red_q_bl_o(red_q_bl_o), .red_qinv_o(red_qinv_o),
      .red_result_i(red_result_i), .red_valid_i(red_valid_i), .rsp_valid_o(rsp_valid_o),
      .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i), .idle_o(idle_o), .error_o(error_o)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit mon_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model state
   typedef struct packed { int due; logic id; logic [63:0] val; } flight_t;
   flight_t     flight[$];
   logic [63:0] fq0[$], fq1[$];
   int          cnt_m[2];
   bit          last_m    = 1'b1;
   bit          exp_start = 1'b0;
   logic [63:0] exp_x     = '0;
   bit          err_m     = 1'b0;
   int          acc_cnt[2], pop_cnt[2];
   bit          grant_log[$];
   int          t_start_first = -1, t_rsp0_first = -1, rsp1_seen = 0, rsp_seen_any = 0;

   bit [1:0]    m_elig, m_acc, m_pop;
   bit          m_tag, m_idle, m_g;
   logic [63:0] m_head0, m_head1;

   always @(negedge clk) begin
      if (mon_en) begin
         m_acc = '0;
         if (!rst_i) begin
            for (int k = 0; k < 2; k++) m_elig[k] = req_valid_i[k] && (cnt_m[k] < DEPTH);
            if (m_elig == 2'b11) m_acc = last_m ? 2'b01 : 2'b10;
            else m_acc = m_elig;
         end
         m_idle  = (cnt_m[0] == 0) && (cnt_m[1] == 0) && (flight.size() == 0) && !exp_start
                   && (fq0.size() == 0) && (fq1.size() == 0);
         m_head0 = (fq0.size() != 0) ? fq0[0] : 64'd0;
         m_head1 = (fq1.size() != 0) ? fq1[0] : 64'd0;
         if (rst_i) check("ready_in_reset", req_ready_o, 0);
         check("accept", req_ready_o & req_valid_i, m_acc);
         check("red_start", red_start_o, exp_start);
         check("red_x", red_x_o, exp_x);
         check("rsp_valid", rsp_valid_o, {fq1.size() != 0, fq0.size() != 0});
         check("rsp_data0", rsp_data_o[0], m_head0);
         check("rsp_data1", rsp_data_o[1], m_head1);
         check("idle", idle_o, m_idle);
         check("error", error_o, err_m);

         if (red_start_o && t_start_first < 0) t_start_first = cyc;
         if (rsp_valid_o[0] && t_rsp0_first < 0) t_rsp0_first = cyc;
         if (rsp_valid_o[1]) rsp1_seen++;
         if (|rsp_valid_o) rsp_seen_any++;

         if (rst_i) begin
            flight.delete(); fq0.delete(); fq1.delete();
            cnt_m[0] = 0; cnt_m[1] = 0;
            last_m = 1'b1; exp_start = 1'b0; exp_x = '0; err_m = 1'b0;
         end else begin
            m_pop[0] = rsp_ready_i[0] && (fq0.size() != 0);
            m_pop[1] = rsp_ready_i[1] && (fq1.size() != 0);
            if (m_pop[0]) begin void'(fq0.pop_front()); pop_cnt[0]++; end
            if (m_pop[1]) begin void'(fq1.pop_front()); pop_cnt[1]++; end
            m_tag = 1'b0;
            while (flight.size() != 0 && flight[0].due == cyc) begin
               m_tag = 1'b1;
               if (flight[0].id) fq1.push_back(flight[0].val);
               else fq0.push_back(flight[0].val);
               void'(flight.pop_front());
            end
            if (CHECK_EN && (red_valid_i != m_tag)) err_m = 1'b1;
            for (int k = 0; k < 2; k++) cnt_m[k] += int'(m_acc[k]) - int'(m_pop[k]);
            if (m_acc != 2'b00) begin
               m_g       = m_acc[1];
               exp_start = 1'b1;
               exp_x     = req_data_i[m_g];
               flight.push_back('{due: cyc + 1 + LAT, id: m_g, val: req_data_i[m_g] % Q});
               last_m    = m_g;
               acc_cnt[m_g]++;
               grant_log.push_back(m_g);
            end else begin
               exp_start = 1'b0;
            end
         end
      end
   end

   // Behavioural reducer: result LAT cycles after start, value = x mod q; not reset by rst_i.
   logic        hist_v[16];
   logic [63:0] hist_x[16];
   bit          inject = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      hist_v[cyc % 16] = red_start_o;
      hist_x[cyc % 16] = red_x_o;
      red_valid_i  = 1'b0;
      red_result_i = {$urandom, $urandom};
      if (cyc >= LAT && hist_v[(cyc - LAT) % 16]) begin
         red_valid_i  = 1'b1;
         red_result_i = hist_x[(cyc - LAT) % 16] % Q;
      end
      if (inject) begin
         red_valid_i = 1'b1;
         inject      = 1'b0;
      end
   endtask

   task automatic do_reset();
      tick();
      rst_i = 1'b1; req_valid_i = '0; rsp_ready_i = '0;
      tick();
      rst_i = 1'b0;
      acc_cnt[0] = 0; acc_cnt[1] = 0; pop_cnt[0] = 0; pop_cnt[1] = 0;
      grant_log.delete();
   endtask

   task automatic drain(input string name);
      int n;
      req_valid_i = '0; rsp_ready_i = 2'b11;
      n = 0;
      while (!idle_o && n < 100) begin tick(); n++; end
      check(name, idle_o, 1);
   endtask

   int t_acc, bad, a0;

   initial begin
      for (int i = 0; i < 16; i++) begin hist_v[i] = 1'b0; hist_x[i] = '0; end
      cnt_m[0] = 0; cnt_m[1] = 0;
      rst_i = 1'b1; req_valid_i = '0; req_data_i = '0; rsp_ready_i = '0;
      red_valid_i = 1'b0; red_result_i = '0;
      tick();
      mon_en = 1'b1;
      check("reset_idle", idle_o, 1);
      check("reset_start", red_start_o, 0);
      check("reset_x", red_x_o, 0);
      check("reset_rsp_valid", rsp_valid_o, 0);
      check("reset_ready", req_ready_o, 0);
      check("reset_error", error_o, 0);
      check("const_q", red_q_o, 64'd8380417);
      check("const_q_bl", red_q_bl_o, 64'd23);
      check("const_qinv", red_qinv_o, 64'd58728449);
      tick();
      rst_i = 1'b0;

      // Single operand latency
      repeat (3) tick();
      tick();
      req_valid_i = 2'b01; req_data_i[0] = 64'h3;
      t_acc = cyc; t_start_first = -1; t_rsp0_first = -1; rsp1_seen = 0;
      tick();
      req_valid_i = '0;
      repeat (10) tick();
      check("single_start_cycle", t_start_first, t_acc + 1);
      check("single_rsp_cycle", t_rsp0_first, t_acc + 6);
      check("single_rsp_data", rsp_data_o[0], 64'h3);
      check("single_req1_quiet", rsp1_seen, 0);
      rsp_ready_i = 2'b01;
      tick();
      rsp_ready_i = 2'b00;
      check("single_idle", idle_o, 1);

      // Fair sharing
      do_reset();
      for (int i = 0; i < 200 && !(acc_cnt[0] == 16 && acc_cnt[1] == 16 && idle_o); i++) begin
         tick();
         req_valid_i[0] = (acc_cnt[0] < 16);
         req_valid_i[1] = (acc_cnt[1] < 16);
         req_data_i[0]  = {$urandom, $urandom};
         req_data_i[1]  = {$urandom, $urandom};
         rsp_ready_i    = 2'b11;
      end
      req_valid_i = '0;
      check("fair_grants", grant_log.size(), 32);
      bad = 0;
      for (int i = 0; i < grant_log.size(); i++) if (grant_log[i] != i[0]) bad++;
      check("fair_alternate", bad, 0);
      check("fair_pops0", pop_cnt[0], 16);
      check("fair_pops1", pop_cnt[1], 16);
      check("fair_idle", idle_o, 1);

      // Credit backpressure: requester 1 never pops
      do_reset();
      for (int i = 0; i < 40; i++) begin
         tick();
         req_valid_i = 2'b11;
         req_data_i[0] = {$urandom, $urandom};
         req_data_i[1] = {$urandom, $urandom};
         rsp_ready_i = 2'b01;
      end
      check("credit_acc1", acc_cnt[1], 4);
      check("credit_ready1", req_ready_o[1], 0);
      check("credit_full1", rsp_valid_o[1], 1);
      a0 = acc_cnt[0];
      check("credit_req0_streams", a0 > 12, 1);
      rsp_ready_i = 2'b11;
      tick();
      rsp_ready_i = 2'b01;
      repeat (20) tick();
      check("credit_one_more", acc_cnt[1], 5);

      // Full FIFO drained while results keep arriving
      for (int i = 0; i < 40; i++) begin
         tick();
         req_valid_i = 2'b11;
         req_data_i[0] = {$urandom, $urandom};
         req_data_i[1] = {$urandom, $urandom};
         rsp_ready_i = 2'b11;
      end
      drain("full_drain_idle");
      check("full_conserve0", pop_cnt[0], acc_cnt[0]);
      check("full_conserve1", pop_cnt[1], acc_cnt[1]);
      check("full_no_error", error_o, 0);

      // Reset with three operands in flight
      do_reset();
      rsp_ready_i = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         req_valid_i = 2'b01;
         req_data_i[0] = {$urandom, $urandom};
      end
      tick();
      req_valid_i = '0; rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("rst_idle", idle_o, 1);
      check("rst_rsp_valid", rsp_valid_o, 0);
      check("rst_start", red_start_o, 0);
      check("rst_x", red_x_o, 0);
      rsp_seen_any = 0;
      repeat (15) tick();
      check("rst_late_dropped", rsp_seen_any, 0);
      check("rst_idle_after", idle_o, 1);
      check("rst_error_after", error_o, CHECK_EN);

      // Spurious reducer valid with empty tag pipeline
      do_reset();
      repeat (3) tick();
      inject = 1'b1;
      tick();
      tick();
      check("spurious_error", error_o, CHECK_EN);
      repeat (5) tick();
      check("spurious_sticky", error_o, CHECK_EN);
      check("spurious_not_pushed", rsp_valid_o, 0);
      do_reset();
      check("spurious_cleared", error_o, 0);

      // Randomized traffic with occasional reset
      for (int i = 0; i < 2000; i++) begin
         tick();
         rst_i = ($urandom_range(0, 299) == 0);
         req_valid_i[0] = ($urandom_range(0, 3) != 0);
         req_valid_i[1] = ($urandom_range(0, 2) != 0);
         req_data_i[0]  = {$urandom, $urandom};
         req_data_i[1]  = {$urandom, $urandom};
         rsp_ready_i[0] = ($urandom_range(0, 2) != 0);
         rsp_ready_i[1] = ($urandom_range(0, 3) == 0);
      end
      tick();
      rst_i = 1'b0;
      drain("random_drain_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
